// File: rtl/ucsbece154b_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ucsbece154b_mem_arbiter_pkg
//   Shared definitions for the backing-memory arbiter:
//     - arb_state_t : arbiter FSM states (ARB_IDLE, ARB_I, ARB_D)
//     - GNT_I/GNT_D : grant encoding; also the bit position of each side in
//                     the 2-bit request/grant vectors
//     - rr_pick     : round-robin choice between the two requesters
// ---------------------------------------------------------------------------
package ucsbece154b_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_I    = 2'd1,
      ARB_D    = 2'd2
   } arb_state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // One-hot grant for req = {d, i}. On a tie the side that did not win
   // last time gets the grant.
   function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                          input logic       last_grant);
      logic [1:0] g;
      g = 2'b00;
      case (req)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = (last_grant == GNT_D) ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/ucsbece154b_mem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// ucsbece154b_rr_arbiter2
//   Two-requester round-robin picker. Holds last_grant, which resets to D so
//   that the icache side wins the first tie after reset.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous, active-high reset
//   req     in   [1:0] requests, bit GNT_I = icache, bit GNT_D = data
//   gnt_en  in   grant may be issued this cycle
//   gnt     out  [1:0] one-hot grant (combinational), zero when !gnt_en
// ---------------------------------------------------------------------------
module ucsbece154b_rr_arbiter2
   import ucsbece154b_mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       gnt_en,
   output logic [1:0] gnt
);

   logic last_grant;

   assign gnt = gnt_en ? rr_pick(req, last_grant) : 2'b00;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GNT_D;
      end else if (|gnt) begin
         last_grant <= gnt[GNT_D] ? GNT_D : GNT_I;
      end
   end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ucsbece154b_mem_arbiter
//   Shares the single backing-memory port between the icache refill path
//   (BLOCK_WORDS-word bursts) and the data path (single-word reads/writes).
//   Round-robin on simultaneous requests; a transaction is never interleaved
//   with another. All outputs are registered and reset to zero.
//
//   Optional build macro ARB_CRITICAL_WORD_FIRST_EN: when defined, a refill
//   burst starts at the missed word and wraps within the block; otherwise it
//   always starts at word 0.
//
// Parameters:
//   BLOCK_WORDS  words per icache block (power of 2, 2..16)
//   ADDR_W       byte-address width
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req_i, i_addr_i          icache refill request / miss byte address
//   i_valid_o, i_data_o        one-cycle refill word strobe and data
//   i_last_o                   final word of a burst
//   d_req_i, d_we_i            data request, 1 = write
//   d_addr_i, d_wdata_i        word-aligned address, write data
//   d_rdata_o, d_done_o        read data, one-cycle completion strobe
//   mem_req_o, mem_we_o        memory request (held until ack), write enable
//   mem_addr_o, mem_wdata_o    word-aligned address, write data
//   mem_ack_i, mem_rdata_i     access complete, read data
// ---------------------------------------------------------------------------
module ucsbece154b_mem_arbiter
   import ucsbece154b_mem_arbiter_pkg::*;
#(
   parameter int BLOCK_WORDS = 4,
   parameter int ADDR_W      = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_valid_o,
   output logic [31:0]       i_data_o,
   output logic              i_last_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [31:0]       d_wdata_i,
   output logic [31:0]       d_rdata_o,
   output logic              d_done_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i
);

   localparam int             OFF      = $clog2(BLOCK_WORDS);
   localparam logic [OFF-1:0] LAST_CNT = OFF'(BLOCK_WORDS - 1);

   arb_state_t            state;
   logic [OFF-1:0]        idx;        // word index within the block
   logic [OFF-1:0]        idx_next;
   logic [OFF-1:0]        cnt;        // words already delivered
   logic [OFF-1:0]        start_idx;
   logic [ADDR_W-OFF-3:0] i_base;     // block address latched at grant
   logic [1:0]            gnt;
   logic                  unused_addr_bits;

`ifdef ARB_CRITICAL_WORD_FIRST_EN
   assign start_idx = i_addr_i[OFF+1:2];
`else
   assign start_idx = '0;
`endif

   // Byte offset bits never reach the memory address; word-select bits only
   // do so in the critical-word-first build.
   assign unused_addr_bits = ^i_addr_i[OFF+1:0];

   // Power-of-2 block size: the natural wrap of idx is the modulo.
   assign idx_next = idx + OFF'(1);

   ucsbece154b_rr_arbiter2 u_rr (
      .clk    (clk),
      .reset  (reset),
      .req    ({d_req_i, i_req_i}),
      .gnt_en (state == ARB_IDLE),
      .gnt    (gnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ARB_IDLE;
         idx         <= '0;
         cnt         <= '0;
         i_base      <= '0;
         i_valid_o   <= 1'b0;
         i_data_o    <= '0;
         i_last_o    <= 1'b0;
         d_rdata_o   <= '0;
         d_done_o    <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         // Strobes are single-cycle unless re-raised below.
         i_valid_o <= 1'b0;
         i_last_o  <= 1'b0;
         d_done_o  <= 1'b0;

         case (state)
            ARB_IDLE: begin
               if (gnt[GNT_I]) begin
                  state      <= ARB_I;
                  i_base     <= i_addr_i[ADDR_W-1:OFF+2];
                  idx        <= start_idx;
                  cnt        <= '0;
                  mem_req_o  <= 1'b1;
                  mem_we_o   <= 1'b0;
                  mem_addr_o <= {i_addr_i[ADDR_W-1:OFF+2], start_idx, 2'b00};
               end else if (gnt[GNT_D]) begin
                  state       <= ARB_D;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= d_we_i;
                  mem_addr_o  <= d_addr_i;
                  mem_wdata_o <= d_wdata_i;
               end
            end

            ARB_I: begin
               if (mem_req_o && mem_ack_i) begin
                  i_valid_o <= 1'b1;
                  i_data_o  <= mem_rdata_i;
                  if (cnt == LAST_CNT) begin
                     i_last_o  <= 1'b1;
                     mem_req_o <= 1'b0;
                     state     <= ARB_IDLE;
                  end else begin
                     // Keep mem_req_o high so the next word follows back-to-back.
                     cnt        <= cnt + OFF'(1);
                     idx        <= idx_next;
                     mem_addr_o <= {i_base, idx_next, 2'b00};
                  end
               end
            end

            ARB_D: begin
               if (mem_req_o && mem_ack_i) begin
                  d_done_o  <= 1'b1;
                  mem_req_o <= 1'b0;
                  state     <= ARB_IDLE;
                  if (!mem_we_o) begin
                     d_rdata_o <= mem_rdata_i;
                  end
               end
            end

            default: begin
               state     <= ARB_IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
